image_tx_host: RTL and testbench

IMAGE_TX_HOST -- requirements
Module: image_tx_host

---
 rtl/snn_host_pkg.sv | 22 ++
 rtl/img_byte_packer.sv | 30 +++
 rtl/image_tx_host.sv | 151 +++++++++++++++
 tb/tb_image_tx_host.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_host_pkg.sv
// Shared types and constants for the image transmit host: FSM states and the
// ASCII range accepted as a classification result.
package snn_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    WAIT_TX,
    RESP,
    FIN
  } host_state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [3:0] DIGIT_ERR  = 4'hF;

  function automatic logic is_ascii_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/img_byte_packer.sv
// Serial-to-byte packer: collects 8 image bits LSB-first into one byte.
module img_byte_packer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       mem_q,
  output logic [7:0] data,
  output logic       byte_full
);

  logic [2:0] bit_cnt;

  // First bit shifted in ends up in data[0] after eight shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      data    <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      data    <= {mem_q, data[7:1]};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign byte_full = shift_en && (bit_cnt == 3'd7);

endmodule

// File: rtl/image_tx_host.sv
// Streams a 1-bit-wide image over a UART as bytes and collects the ASCII digit
// reply. Define RESP_TIMEOUT_EN to bound the wait for the reply.
module image_tx_host
  import snn_host_pkg::*;
#(
  parameter int unsigned NUM_BITS     = 784,
  parameter int unsigned RESP_TIMEOUT = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [9:0] mem_addr,
  input  logic       mem_q,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_rdy,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic [3:0] digit,
  output logic       err
);

  localparam int unsigned NUM_BYTES = NUM_BITS / 8;
  localparam int unsigned BCW       = $clog2(NUM_BYTES + 1);
  localparam logic [9:0]  LAST_ADDR = 10'(NUM_BITS - 1);

  host_state_t    state, state_nxt;
  logic           phase;
  logic           wait_armed;
  logic [BCW-1:0] byte_cnt;
  logic           start_acc;
  logic           shift_en;
  logic           byte_full;
  logic           tmo_hit;
  logic [7:0]     rx_off;

  assign start_acc = (state == IDLE) && start;
  assign shift_en  = (state == FETCH) && phase;
  assign busy      = (state != IDLE);
  assign rx_off    = rx_data - ASCII_ZERO;

`ifdef RESP_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(RESP_TIMEOUT + 1);
  logic [TCW-1:0] tmo_cnt;

  // Held at zero outside RESP, so it always starts from zero on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if (state != RESP)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == RESP) && (tmo_cnt == TCW'(RESP_TIMEOUT - 1));
`else
  logic unused_resp_timeout;
  assign unused_resp_timeout = ^32'(RESP_TIMEOUT);
  assign tmo_hit = 1'b0;
`endif

  img_byte_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_acc),
    .shift_en (shift_en),
    .mem_q    (mem_q),
    .data     (tx_data),
    .byte_full(byte_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (byte_full) state_nxt = SEND;
      SEND: begin
        if (tx_rdy) begin
          tx_start  = 1'b1;
          state_nxt = WAIT_TX;
        end
      end
      // tx_rdy may still read high in the cycle after tx_start; skip that cycle.
      WAIT_TX: begin
        if (wait_armed && tx_rdy)
          state_nxt = (byte_cnt == BCW'(NUM_BYTES)) ? RESP : FETCH;
      end
      RESP:    if (rx_rdy || tmo_hit) state_nxt = FIN;
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr   <= '0;
      phase      <= 1'b0;
      wait_armed <= 1'b0;
      byte_cnt   <= '0;
      digit      <= '0;
      err        <= 1'b0;
    end else begin
      wait_armed <= (state == WAIT_TX);
      if (start_acc) begin
        mem_addr <= '0;
        phase    <= 1'b0;
        byte_cnt <= '0;
        digit    <= '0;
        err      <= 1'b0;
      end
      // Address advances after each capture but parks on the last image bit.
      if (state == FETCH) begin
        phase <= ~phase;
        if (phase && (mem_addr != LAST_ADDR))
          mem_addr <= mem_addr + 10'd1;
      end
      if (tx_start)
        byte_cnt <= byte_cnt + 1'b1;
      if (state == RESP) begin
        if (rx_rdy) begin
          if (is_ascii_digit(rx_data)) begin
            digit <= rx_off[3:0];
            err   <= 1'b0;
          end else begin
            digit <= DIGIT_ERR;
            err   <= 1'b1;
          end
        end else if (tmo_hit) begin
          digit <= DIGIT_ERR;
          err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_image_tx_host.sv
// Self-checking bench for image_tx_host: random images and UART handshakes
// against a byte-level reference model.
module tb_image_tx_host;

  localparam int NUM_BITS  = 784;
  localparam int NUM_BYTES = NUM_BITS / 8;
  localparam int TMO       = 100;
  localparam int BUDGET    = 20000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] mem_addr;
  logic       mem_q = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_rdy = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       busy;
  logic       done;
  logic [3:0] digit;
  logic       err;

  always #10 clk = ~clk;

  image_tx_host #(
    .NUM_BITS    (NUM_BITS),
    .RESP_TIMEOUT(TMO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mem_addr(mem_addr),
    .mem_q   (mem_q),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_rdy  (tx_rdy),
    .rx_rdy  (rx_rdy),
    .rx_data (rx_data),
    .busy    (busy),
    .done    (done),
    .digit   (digit),
    .err     (err)
  );

  logic [NUM_BITS-1:0] img = '0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] txq[$];
  int         tx_cyc[$];
  int         tx_cnt, done_cnt, bad_tx, dbl_tx, max_addr;
  int         last_tx_cyc, done_cyc, start_cyc;
  bit         prev_tx = 1'b0;
  bit         got_done;

  // Synchronous 1-bit image memory: data appears the cycle after the address.
  always @(posedge clk) mem_q <= (int'(mem_addr) < NUM_BITS) ? img[mem_addr] : 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_start) begin
      txq.push_back(tx_data);
      tx_cyc.push_back(cyc);
      tx_cnt++;
      last_tx_cyc = cyc;
      if (!tx_rdy) bad_tx++;
      if (prev_tx) dbl_tx++;
    end
    prev_tx = tx_start;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
  end

  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = img[8*k + i];
    return b;
  endfunction

  function automatic int byte_errs();
    int n = 0;
    if (txq.size() != NUM_BYTES) n++;
    for (int k = 0; k < txq.size() && k < NUM_BYTES; k++)
      if (txq[k] !== exp_byte(k)) n++;
    return n;
  endfunction

  function automatic logic [4:0] ref_result(input logic [7:0] reply);
    int v = int'(reply) - 48;
    if (v >= 0 && v <= 9) return {4'(v), 1'b0};
    return {4'hF, 1'b1};
  endfunction

  // mode 0: tx_rdy always high; mode 1: random tx_rdy plus stray rx_rdy/start.
  task automatic run_txn(input int mode, input logic [7:0] reply, input int reply_dly,
                         input int abort_after, input int stall_after, input int budget);
    bit replied = 1'b0;
    txq.delete();
    tx_cyc.delete();
    tx_cnt = 0; done_cnt = 0; bad_tx = 0; dbl_tx = 0; max_addr = 0;
    last_tx_cyc = 0; got_done = 1'b0;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({digit, err} !== 5'b0) begin
      errors++;
      $display("FAIL start_clear: digit/err=%h/%b expected 0/0", digit, err);
    end
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) begin
        got_done = 1'b1;
        break;
      end
      if (abort_after > 0 && tx_cnt >= abort_after) begin
        rst_n = 1'b0;
        break;
      end
      if (tx_cnt >= NUM_BYTES)
        tx_rdy = 1'b1;
      else if (stall_after > 0 && tx_cnt == stall_after &&
               cyc >= last_tx_cyc + 19 && cyc < last_tx_cyc + 1019)
        tx_rdy = 1'b0;
      else if (mode == 1)
        tx_rdy = ($urandom_range(0, 3) != 0);
      else
        tx_rdy = 1'b1;
      rx_rdy = 1'b0;
      if (tx_cnt >= NUM_BYTES) begin
        if (reply_dly > 0 && !replied && cyc == last_tx_cyc + reply_dly) begin
          rx_rdy  = 1'b1;
          rx_data = reply;
          replied = 1'b1;
        end
      end else if (mode == 1 && $urandom_range(0, 15) == 0) begin
        rx_rdy  = 1'b1;
        rx_data = 8'($urandom_range(48, 57));
      end
      start = (mode == 1 && $urandom_range(0, 31) == 0);
      @(posedge clk); #1;
    end
    rx_rdy = 1'b0;
    start  = 1'b0;
    tx_rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, tx_start} !== 3'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/tx_start=%b expected 000", {busy, done, tx_start});
    end
    checks++;
    if (tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx_data: got %h expected 00", tx_data);
    end
    checks++;
    if (mem_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_mem_addr: got %0d expected 0", mem_addr);
    end
    checks++;
    if ({digit, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_result: digit/err=%h/%b expected 0/0", digit, err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alternating();
    for (int a = 0; a < NUM_BITS; a++) img[a] = a[0];
    run_txn(0, 8'h37, $urandom_range(3, 20), 0, 0, BUDGET);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (txq.size() != NUM_BYTES || byte_errs() != 0) begin
      errors++;
      $display("FAIL alt_bytes: got %0d bytes (%0d bad) expected %0d of AA", txq.size(), byte_errs(), NUM_BYTES);
    end
    checks++;
    if (tx_cyc.size() == 0 || tx_cyc[0] - start_cyc != 17) begin
      errors++;
      $display("FAIL alt_latency: got %0d expected 17", tx_cyc.size() ? tx_cyc[0] - start_cyc : -1);
    end
    checks++;
    if (!got_done || done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL alt_done: done pulses %0d busy %b expected 1 and 0", done_cnt, busy);
    end
    checks++;
    if ({digit, err} !== {4'd7, 1'b0}) begin
      errors++;
      $display("FAIL alt_result: digit/err=%h/%b expected 7/0", digit, err);
    end
    checks++;
    if (bad_tx != 0 || dbl_tx != 0) begin
      errors++;
      $display("FAIL alt_tx_pulse: bad %0d double %0d expected 0 0", bad_tx, dbl_tx);
    end
  endtask

  task automatic test_single_bit();
    img = '0;
    img[0] = 1'b1;
    run_txn(0, 8'h32, $urandom_range(3, 20), 0, 0, BUDGET);
    checks++;
    if (txq.size() == 0 || txq[0] !== 8'h01) begin
      errors++;
      $display("FAIL single_first: got %h expected 01", txq.size() ? txq[0] : 8'hxx);
    end
    checks++;
    if (byte_errs() != 0) begin
      errors++;
      $display("FAIL single_bytes: %0d bad of %0d expected 0 bad of %0d", byte_errs(), txq.size(), NUM_BYTES);
    end
    checks++;
    if (max_addr != NUM_BITS - 1) begin
      errors++;
      $display("FAIL single_max_addr: got %0d expected %0d", max_addr, NUM_BITS - 1);
    end
  endtask

  task automatic test_replies();
    logic [7:0] replies[5] = '{8'h41, 8'h2F, 8'h30, 8'h39, 8'h3A};
    for (int r = 0; r < 5; r++) begin
      for (int a = 0; a < NUM_BITS; a++) img[a] = 1'($urandom_range(0, 1));
      run_txn(0, replies[r], $urandom_range(3, 20), 0, 0, BUDGET);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({digit, err} !== ref_result(replies[r]) || done_cnt != 1) begin
        errors++;
        $display("FAIL reply_%h: digit/err=%h/%b done %0d expected %h/%b done 1",
                 replies[r], digit, err, done_cnt, ref_result(replies[r]) >> 1, ref_result(replies[r]) & 5'd1);
      end
    end
  endtask

  task automatic test_random_traffic();
    for (int t = 0; t < 3; t++) begin
      logic [7:0] reply = 8'($urandom_range(48, 57));
      for (int a = 0; a < NUM_BITS; a++) img[a] = 1'($urandom_range(0, 1));
      run_txn(1, reply, $urandom_range(3, 30), 0, 0, BUDGET);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (byte_errs() != 0 || bad_tx != 0 || dbl_tx != 0) begin
        errors++;
        $display("FAIL rand_bytes_%0d: %0d bad of %0d, bad_tx %0d dbl %0d expected all 0 of %0d",
                 t, byte_errs(), txq.size(), bad_tx, dbl_tx, NUM_BYTES);
      end
      checks++;
      if ({digit, err} !== ref_result(reply) || done_cnt != 1) begin
        errors++;
        $display("FAIL rand_result_%0d: digit/err=%h/%b done %0d expected %h/0 done 1",
                 t, digit, err, done_cnt, reply - 8'h30);
      end
    end
  endtask

  task automatic test_tx_stall();
    for (int a = 0; a < NUM_BITS; a++) img[a] = 1'($urandom_range(0, 1));
    run_txn(0, 8'h34, 5, 0, 6, BUDGET);
    checks++;
    if (tx_cyc.size() < 7 || tx_cyc[6] - tx_cyc[5] != 1019) begin
      errors++;
      $display("FAIL stall_gap: got %0d expected 1019", tx_cyc.size() >= 7 ? tx_cyc[6] - tx_cyc[5] : -1);
    end
    checks++;
    if (byte_errs() != 0 || bad_tx != 0) begin
      errors++;
      $display("FAIL stall_bytes: %0d bad, bad_tx %0d expected 0 0", byte_errs(), bad_tx);
    end
    checks++;
    if ({digit, err} !== {4'd4, 1'b0}) begin
      errors++;
      $display("FAIL stall_result: digit/err=%h/%b expected 4/0", digit, err);
    end
  endtask

  task automatic test_reset_abort();
    for (int a = 0; a < NUM_BITS; a++) img[a] = 1'($urandom_range(0, 1));
    run_txn(0, 8'h31, 5, 41, 0, BUDGET);
    #1;
    checks++;
    if ({busy, tx_start, done} !== 3'b0) begin
      errors++;
      $display("FAIL abort_outputs: busy/tx_start/done=%b expected 000", {busy, tx_start, done});
    end
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (tx_cnt != 41 || done_cnt != 0) begin
      errors++;
      $display("FAIL abort_quiet: tx %0d done %0d expected 41 0", tx_cnt, done_cnt);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < NUM_BITS; a++) img[a] = 1'($urandom_range(0, 1));
    run_txn(0, 8'h38, 7, 0, 0, BUDGET);
    checks++;
    if (txq.size() == 0 || txq[0] !== exp_byte(0) || byte_errs() != 0) begin
      errors++;
      $display("FAIL abort_restart: %0d bad of %0d expected 0 bad of %0d", byte_errs(), txq.size(), NUM_BYTES);
    end
    checks++;
    if ({digit, err} !== {4'd8, 1'b0} || done_cnt != 1) begin
      errors++;
      $display("FAIL abort_result: digit/err=%h/%b done %0d expected 8/0 done 1", digit, err, done_cnt);
    end
  endtask

`ifdef RESP_TIMEOUT_EN
  task automatic test_timeout();
    for (int a = 0; a < NUM_BITS; a++) img[a] = 1'($urandom_range(0, 1));
    run_txn(0, 8'h00, 0, 0, 0, BUDGET);
    checks++;
    if (!got_done || done_cyc - last_tx_cyc != 3 + TMO) begin
      errors++;
      $display("FAIL tmo_latency: got %0d expected %0d", got_done ? done_cyc - last_tx_cyc : -1, 3 + TMO);
    end
    checks++;
    if ({digit, err} !== {4'hF, 1'b1}) begin
      errors++;
      $display("FAIL tmo_result: digit/err=%h/%b expected F/1", digit, err);
    end
    run_txn(0, 8'h33, 2 + TMO, 0, 0, BUDGET);
    checks++;
    if ({digit, err} !== {4'd3, 1'b0} || done_cyc - last_tx_cyc != 3 + TMO) begin
      errors++;
      $display("FAIL tmo_coincide: digit/err=%h/%b at %0d expected 3/0 at %0d",
               digit, err, done_cyc - last_tx_cyc, 3 + TMO);
    end
  endtask
`else
  task automatic test_no_timeout();
    for (int a = 0; a < NUM_BITS; a++) img[a] = 1'($urandom_range(0, 1));
    run_txn(0, 8'h00, 0, 0, 0, NUM_BYTES * 19 + 600);
    checks++;
    if (done_cnt != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL resp_wait: done %0d busy %b expected 0 1", done_cnt, busy);
    end
    rx_rdy  = 1'b1;
    rx_data = 8'h35;
    @(posedge clk); #1;
    rx_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({digit, err} !== {4'd5, 1'b0} || done_cnt != 1) begin
      errors++;
      $display("FAIL resp_late: digit/err=%h/%b done %0d expected 5/0 done 1", digit, err, done_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alternating();
    test_single_bit();
    test_replies();
    test_random_traffic();
    test_tx_stall();
    test_reset_abort();
`ifdef RESP_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
